// File: rtl/pipeline_stall_ctrl.sv
// Hazard and stall sequencer for the 5-stage pipeline: load-use bubbles, taken-branch flushes
// and variable-latency data-memory waits with timeout.
module pipeline_stall_ctrl #(
    parameter int unsigned WAIT_LIMIT = 16,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic [4:0]       ex_rd,
    input  logic             ex_memread,
    input  logic             ex_branch_taken,
    input  logic             mem_access,
    input  logic             dmem_ready,
    output logic             dmem_req,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_flush,
    output logic             exmem_en,
    output logic             memwb_bubble,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int unsigned WCNT_W = $clog2(WAIT_LIMIT + 1);

    typedef enum logic [0:0] {
        StRun,
        StMemWait
    } state_e;

    state_e            state_q, state_d;
    logic [WCNT_W-1:0] wait_q, wait_d;
    logic              err_q, err_d;
    logic              ignore_q, ignore_d;
    logic [CNT_W-1:0]  stall_q, stall_d;

    logic load_use;
    logic mem_eff;
    logic mem_stall;
    logic timeout;

    always_comb begin
        load_use = ex_memread && (ex_rd != 5'd0) &&
                   ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));
        // The cycle after an abandoned access must not re-issue it.
        mem_eff   = mem_access && !ignore_q;
        mem_stall = (state_q == StRun) ? (mem_eff && !dmem_ready) : !dmem_ready;
        timeout   = (state_q == StMemWait) && !dmem_ready &&
                    (wait_q == WCNT_W'(WAIT_LIMIT));
    end

    always_comb begin
        dmem_req     = 1'b0;
        pc_en        = 1'b0;
        ifid_en      = 1'b0;
        ifid_flush   = 1'b0;
        idex_en      = 1'b0;
        idex_flush   = 1'b0;
        exmem_en     = 1'b0;
        memwb_bubble = 1'b0;
        if (!reset) begin
            dmem_req = (state_q == StMemWait) || mem_eff;
            if (mem_stall) begin
                memwb_bubble = 1'b1;
            end else if (ex_branch_taken) begin
                pc_en      = 1'b1;
                ifid_en    = 1'b1;
                ifid_flush = 1'b1;
                idex_en    = 1'b1;
                idex_flush = 1'b1;
                exmem_en   = 1'b1;
            end else if (load_use) begin
                idex_en    = 1'b1;
                idex_flush = 1'b1;
                exmem_en   = 1'b1;
            end else begin
                pc_en    = 1'b1;
                ifid_en  = 1'b1;
                idex_en  = 1'b1;
                exmem_en = 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        wait_d   = wait_q;
        err_d    = err_q;
        ignore_d = 1'b0;
        unique case (state_q)
            StRun: begin
                if (mem_stall) begin
                    state_d = StMemWait;
                    wait_d  = WCNT_W'(1);
                end
            end
            StMemWait: begin
                if (dmem_ready) begin
                    state_d = StRun;
                    wait_d  = '0;
                end else if (timeout) begin
                    state_d  = StRun;
                    wait_d   = '0;
                    err_d    = 1'b1;
                    ignore_d = 1'b1;
                end else begin
                    wait_d = wait_q + WCNT_W'(1);
                end
            end
            default: begin
                state_d = StRun;
                wait_d  = '0;
            end
        endcase
        stall_d = (!pc_en && (stall_q != {CNT_W{1'b1}})) ? stall_q + CNT_W'(1) : stall_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StRun;
            wait_q   <= '0;
            err_q    <= 1'b0;
            ignore_q <= 1'b0;
            stall_q  <= '0;
        end else begin
            state_q  <= state_d;
            wait_q   <= wait_d;
            err_q    <= err_d;
            ignore_q <= ignore_d;
            stall_q  <= stall_d;
        end
    end

    assign mem_err      = err_q;
    assign stall_cycles = stall_q;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Scoreboard bench for pipeline_stall_ctrl: directed vectors push expected controls, a negedge
// monitor pops and compares against the DUT.
module tb_pipeline_stall_ctrl;

    localparam int unsigned CNT_W = 4;

    logic             clk;
    logic             reset;
    logic [4:0]       id_rs, id_rt, ex_rd;
    logic             id_uses_rt, ex_memread, ex_branch_taken, mem_access, dmem_ready;
    logic             dmem_req, pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en;
    logic             memwb_bubble, mem_err;
    logic [CNT_W-1:0] stall_cycles;

    pipeline_stall_ctrl #(
        .WAIT_LIMIT(4),
        .CNT_W     (CNT_W)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .id_rs          (id_rs),
        .id_rt          (id_rt),
        .id_uses_rt     (id_uses_rt),
        .ex_rd          (ex_rd),
        .ex_memread     (ex_memread),
        .ex_branch_taken(ex_branch_taken),
        .mem_access     (mem_access),
        .dmem_ready     (dmem_ready),
        .dmem_req       (dmem_req),
        .pc_en          (pc_en),
        .ifid_en        (ifid_en),
        .ifid_flush     (ifid_flush),
        .idex_en        (idex_en),
        .idex_flush     (idex_flush),
        .exmem_en       (exmem_en),
        .memwb_bubble   (memwb_bubble),
        .mem_err        (mem_err),
        .stall_cycles   (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string            name;
        logic [7:0]       ctl;
        logic             err;
        logic [CNT_W-1:0] stall;
    } exp_t;

    exp_t             sb[$];
    int               checks = 0;
    int               passed = 0;
    logic             exp_err = 1'b0;
    logic [CNT_W-1:0] exp_stall = '0;

    // Control byte: {dmem_req, pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, bubble}
    localparam logic [7:0] C_RST  = 8'h00;
    localparam logic [7:0] C_RUN  = 8'h6A;
    localparam logic [7:0] C_ZW   = 8'hEA;
    localparam logic [7:0] C_LU   = 8'h0E;
    localparam logic [7:0] C_BR   = 8'h7E;
    localparam logic [7:0] C_FRZ  = 8'h81;
    localparam logic [7:0] C_BRRL = 8'hFE;

    task automatic check_now(input string name, input logic ok);
        checks++;
        if (ok) begin
            passed++;
        end else begin
            $display("FAIL %s: dmem_req=%b pc_en=%b ifid_en=%b idex_en=%b exmem_en=%b err=%b stall=%0d",
                     name, dmem_req, pc_en, ifid_en, idex_en, exmem_en, mem_err, stall_cycles);
        end
    endtask

    task automatic step(input string name, input logic rst, input logic [4:0] rs,
                        input logic [4:0] rt, input logic urt, input logic [4:0] rd,
                        input logic mr, input logic br, input logic macc, input logic rdy,
                        input logic [7:0] exp_ctl);
        exp_t e;
        reset           = rst;
        id_rs           = rs;
        id_rt           = rt;
        id_uses_rt      = urt;
        ex_rd           = rd;
        ex_memread      = mr;
        ex_branch_taken = br;
        mem_access      = macc;
        dmem_ready      = rdy;
        if (rst) begin
            exp_stall = '0;
            exp_err   = 1'b0;
        end
        e.name  = name;
        e.ctl   = exp_ctl;
        e.err   = exp_err;
        e.stall = exp_stall;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (!rst && !exp_ctl[6] && exp_stall != {CNT_W{1'b1}}) exp_stall = exp_stall + 1'b1;
    endtask

    task automatic idle(input string name, input logic [7:0] exp_ctl);
        step(name, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, exp_ctl);
    endtask

    task automatic do_reset(input string name);
        step(name, 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, C_RST);
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            logic [7:0] got;
            e   = sb.pop_front();
            got = {dmem_req, pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en,
                   memwb_bubble};
            checks++;
            if (got === e.ctl && mem_err === e.err && stall_cycles === e.stall) begin
                passed++;
            end else begin
                $display("FAIL %s: got ctl=%b err=%b stall=%0d, expected ctl=%b err=%b stall=%0d",
                         e.name, got, mem_err, stall_cycles, e.ctl, e.err, e.stall);
            end
        end
    end

    initial begin
        reset = 1'b1;
        {id_rs, id_rt, ex_rd} = '0;
        {id_uses_rt, ex_memread, ex_branch_taken, mem_access, dmem_ready} = '0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 3; i++) do_reset("reset_hold");
        check_now("reset_state", dmem_req === 1'b0 && pc_en === 1'b0 && ifid_en === 1'b0 &&
                  idex_en === 1'b0 && exmem_en === 1'b0 && stall_cycles === '0 &&
                  mem_err === 1'b0);
        idle("after_reset", C_RUN);

        step("load_use", 1'b0, 5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, C_LU);
        idle("lu_bubble_done", C_RUN);
        step("lu_rd_zero", 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, C_RUN);
        step("lu_rt_unused", 1'b0, 5'd1, 5'd5, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, C_RUN);
        step("lu_rt_used", 1'b0, 5'd1, 5'd5, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, C_LU);
        step("branch_over_lu", 1'b0, 5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, C_BR);

        do_reset("reset_pre_wait");
        idle("idle_pre_wait", C_RUN);
        step("wait_run", 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, C_FRZ);
        step("wait_1", 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, C_FRZ);
        step("wait_2", 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, C_FRZ);
        step("wait_release", 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, C_ZW);
        idle("after_release", C_RUN);
        step("zero_wait", 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, C_ZW);
        step("br_in_wait_run", 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, C_FRZ);
        step("br_in_wait_1", 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, C_FRZ);
        step("br_release", 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, C_BRRL);
        idle("after_br_release", C_RUN);

        do_reset("reset_pre_timeout");
        idle("idle_pre_timeout", C_RUN);
        for (int i = 0; i < 5; i++) begin
            step("timeout_freeze", 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, C_FRZ);
        end
        check_now("timeout_expired", mem_err === 1'b1 && pc_en === 1'b1 && dmem_req === 1'b0 &&
                  stall_cycles === CNT_W'(5));
        exp_err = 1'b1;
        step("timeout_ignore", 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, C_RUN);
        step("new_access", 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, C_FRZ);
        step("new_release", 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, C_ZW);
        idle("err_sticky", C_RUN);

        do_reset("reset_pre_mid");
        idle("idle_pre_mid", C_RUN);
        step("mid_run", 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, C_FRZ);
        step("mid_wait_1", 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, C_FRZ);
        step("mid_wait_2", 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, C_FRZ);
        do_reset("mid_reset");
        idle("mid_after_reset", C_RUN);
        step("mid_zero_wait", 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, C_ZW);

        for (int i = 0; i < 18; i++) begin
            step("saturate", 1'b0, 5'd7, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, C_LU);
        end
        idle("saturated_hold", C_RUN);

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
